// File: rtl/mini_i_fetch.sv
// Purpose: instruction fetch front end; issues sequential fetches, buffers responses, handles redirects.
// Latency: a response accepted in cycle N is visible on inst/inst_pc in cycle N+1 when the buffer is empty.
// Backpressure: requests are credit-limited (in-flight + buffered < fifo_depth), so responses are always accepted.
// Optional build: MINI_I_FETCH_PERF_EN adds perf_fetch_cnt / perf_discard_cnt outputs.
module mini_i_fetch #(
    parameter int                    data_width = 32,
    parameter int                    addr_width = 32,
    parameter logic [addr_width-1:0] reset_pc   = '0,
    parameter int                    fifo_depth = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [addr_width-1:0] ir_addr,
    input  logic                  ir_data_valid,
    input  logic [data_width-1:0] ir_data,
    output logic                  ir_data_ready,
    input  logic                  redirect_valid,
    input  logic [addr_width-1:0] redirect_pc,
`ifdef MINI_I_FETCH_PERF_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_discard_cnt,
`endif
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [data_width-1:0] inst,
    output logic [addr_width-1:0] inst_pc
);

    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w:0]        depth_c = (cnt_w + 1)'(fifo_depth);
    localparam logic [addr_width-1:0] step    = addr_width'(data_width / 8);

    logic [addr_width-1:0] pc;
    logic [addr_width-1:0] resp_pc;
    logic [cnt_w-1:0]      inflight;
    logic [cnt_w-1:0]      discard;
    logic [cnt_w-1:0]      count;
    logic [ptr_w-1:0]      wr_ptr;
    logic [ptr_w-1:0]      rd_ptr;
    logic [data_width-1:0] data_mem [fifo_depth];
    logic [addr_width-1:0] pc_mem   [fifo_depth];

    logic credit;
    logic req_fire;
    logic resp_fire;
    logic push;
    logic pop;

    // Handshake decode; a redirect suppresses both fetch issue and delivery to decode.
    always_comb begin
        credit        = ({1'b0, inflight} + {1'b0, count}) < depth_c;
        ir_data_ready = 1'b1;
        ir_addr       = reset ? reset_pc : pc;
        ir_addr_valid = !reset && !redirect_valid && credit;
        inst_valid    = !reset && !redirect_valid && (count != '0);
        inst          = data_mem[rd_ptr];
        inst_pc       = pc_mem[rd_ptr];
        req_fire      = ir_addr_valid && ir_addr_ready;
        resp_fire     = ir_data_valid && ir_data_ready;
        push          = resp_fire && !redirect_valid && (discard == '0);
        pop           = inst_valid && inst_ready;
    end

    // Fetch PC, expected-response PC and outstanding/stale request accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= reset_pc;
            resp_pc  <= reset_pc;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_valid) begin
            // Every request still outstanding after this cycle belongs to the old path.
            pc       <= redirect_pc;
            resp_pc  <= redirect_pc;
            inflight <= inflight - cnt_w'(resp_fire);
            discard  <= inflight - cnt_w'(resp_fire);
        end else begin
            if (req_fire) begin
                pc <= pc + step;
            end
            if (push) begin
                resp_pc <= resp_pc + step;
            end
            inflight <= inflight + cnt_w'(req_fire) - cnt_w'(resp_fire);
            if (resp_fire && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

    // Instruction buffer pointers; a redirect flushes everything buffered.
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + cnt_w'(push) - cnt_w'(pop);
        end
    end

    // Buffer storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= ir_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

`ifdef MINI_I_FETCH_PERF_EN
    logic drop;
    assign drop = resp_fire && !push;

    // Wrapping event counters for buffered and dropped responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (drop) begin
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule
